// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32 core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and counts retirements.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic             rf_we_o,
  output logic [1:0]       wb_src_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t        state, next_state;
  logic [WW-1:0] wait_cnt;
  logic          cnt_clr, cnt_inc, retire, set_ill, set_berr;
  logic          legal, is_load, is_store, timeout;

  assign is_load  = (op_i == OP_LOAD);
  assign is_store = (op_i == OP_STORE);
  assign legal    = (op_i == OP_JAL)   || (op_i == OP_JALR)   || (op_i == OP_IMM) ||
                    (op_i == OP_REG)   || (op_i == OP_STORE)  || (op_i == OP_BRANCH) ||
                    (op_i == OP_LUI)   || (op_i == OP_LOAD);
  // A ready on the timeout cycle still completes the access.
  assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == WW'(MEM_TIMEOUT)) && !mem_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      instret_o <= '0;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state <= next_state;
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
      if (retire)   instret_o <= instret_o + 1'b1;
      if (set_ill)  illegal_o <= 1'b1;
      if (set_berr) bus_err_o <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_src_o   = 2'b00;
    rf_we_o    = 1'b0;
    wb_src_o   = 2'b00;
    halted_o   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    retire     = 1'b0;
    set_ill    = 1'b0;
    set_berr   = 1'b0;
    unique case (state)
      IDLE: begin
        next_state = FETCH;
        cnt_clr    = 1'b1;
      end
      FETCH: begin
        if (mem_ready_i) begin
          mem_req_o  = 1'b1;
          ir_we_o    = 1'b1;
          cnt_clr    = 1'b1;
          next_state = DECODE;
        end else if (timeout) begin
          set_berr   = 1'b1;
          next_state = HALT;
        end else begin
          mem_req_o = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      DECODE: begin
        if (legal) next_state = EXEC;
        else begin
          set_ill    = 1'b1;
          next_state = HALT;
        end
      end
      EXEC: begin
        pc_we_o = 1'b1;
        if (op_i == OP_JAL)                          pc_src_o = 2'b01;
        else if (op_i == OP_JALR)                    pc_src_o = 2'b10;
        else if (op_i == OP_BRANCH && branch_taken_i) pc_src_o = 2'b01;
        if (is_load || is_store) begin
          next_state = MEM;
          cnt_clr    = 1'b1;
        end else if (op_i == OP_BRANCH) begin
          next_state = FETCH;
          retire     = 1'b1;
          cnt_clr    = 1'b1;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        if (mem_ready_i || !timeout) begin
          mem_req_o  = 1'b1;
          mem_we_o   = is_store;
          addr_sel_o = 1'b1;
        end
        if (mem_ready_i) begin
          cnt_clr = 1'b1;
          if (is_store) begin
            next_state = FETCH;
            retire     = 1'b1;
          end else begin
            next_state = WB;
          end
        end else if (timeout) begin
          set_berr   = 1'b1;
          next_state = HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WB: begin
        rf_we_o = 1'b1;
        if (is_load)                                wb_src_o = 2'b01;
        else if (op_i == OP_JAL || op_i == OP_JALR) wb_src_o = 2'b10;
        else if (op_i == OP_LUI)                    wb_src_o = 2'b11;
        next_state = FETCH;
        retire     = 1'b1;
        cnt_clr    = 1'b1;
      end
      HALT: begin
        halted_o = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instruction streams, each
// expanded into a per-cycle expected output trace from the phase rules.
module tb_multicycle_ctrl;

  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, IMM = 7'b0010011,
                         REG = 7'b0110011, ST = 7'b0100011, BR = 7'b1100011,
                         LUI = 7'b0110111, LD = 7'b0000011, SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic        br, rdy;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we;
  logic [1:0]  pc_src, wb_src;
  logic        illegal, bus_err, halted;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret  = '0;
  logic [6:0]  op_tab [8] = '{JAL, JALR, IMM, REG, ST, BR, LUI, LD};

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_i(op), .branch_taken_i(br), .mem_ready_i(rdy),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_sel_o(addr_sel), .ir_we_o(ir_we),
    .pc_we_o(pc_we), .pc_src_o(pc_src), .rf_we_o(rf_we), .wb_src_o(wb_src),
    .illegal_o(illegal), .bus_err_o(bus_err), .halted_o(halted), .instret_o(instret)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, rf_we, wb_src,
                illegal, bus_err, halted};

  function automatic logic [12:0] pk(input logic req, we, asel, irwe, pcwe,
                                     input logic [1:0] pcs, input logic rfwe,
                                     input logic [1:0] wbs, input logic ill, berr, hlt);
    return {req, we, asel, irwe, pcwe, pcs, rfwe, wbs, ill, berr, hlt};
  endfunction

  task automatic chk_out(input string tag, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    n_checks++;
    assert (instret === exp_ret) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instret, exp_ret);
    end
  endtask

  // One clock: drive ready, compare outputs mid-cycle, then step past the edge.
  task automatic cyc(input logic r, input logic [12:0] exp, input string tag);
    rdy = r;
    @(negedge clk);
    chk_out(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_ret = '0;
    chk_out("reset_outputs", '0);
    chk_ret("reset_instret");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'($urandom_range(0, 1)), '0, "idle");
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++) cyc(1'b0, pk(1,0,0,0,0,2'd0,0,2'd0,0,0,0), "fetch_wait");
    cyc(1'b1, pk(1,0,0,1,0,2'd0,0,2'd0,0,0,0), "fetch_done");
  endtask

  task automatic run_instr(input logic [6:0] o, input logic b, input int fw, input int mw);
    logic [1:0] pcs, wbs;
    logic       is_mem;
    op = o;
    br = b;
    fetch(fw);
    cyc(1'($urandom_range(0, 1)), '0, "decode");
    pcs = (o == JAL) ? 2'd1 : (o == JALR) ? 2'd2 : (o == BR && b) ? 2'd1 : 2'd0;
    cyc(1'($urandom_range(0, 1)), pk(0,0,0,0,1,pcs,0,2'd0,0,0,0), "exec");
    is_mem = (o == LD) || (o == ST);
    if (is_mem) begin
      for (int i = 0; i < mw; i++)
        cyc(1'b0, pk(1,o == ST,1,0,0,2'd0,0,2'd0,0,0,0), "mem_wait");
      cyc(1'b1, pk(1,o == ST,1,0,0,2'd0,0,2'd0,0,0,0), "mem_done");
    end
    if (o != BR && o != ST) begin
      wbs = (o == LD) ? 2'd1 : (o == JAL || o == JALR) ? 2'd2 : (o == LUI) ? 2'd3 : 2'd0;
      cyc(1'($urandom_range(0, 1)), pk(0,0,0,0,0,2'd0,1,wbs,0,0,0), "wb");
    end
    exp_ret++;
    chk_ret("instret");
  endtask

  task automatic halt_cycles(input logic ill, input logic berr);
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom_range(0, 1)), pk(0,0,0,0,0,2'd0,0,2'd0,ill,berr,1), "halt");
  endtask

  initial begin
    rst = 1'b1;
    op  = IMM;
    br  = 1'b0;
    rdy = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed instruction mix at zero and non-zero memory wait.
    run_instr(IMM, 1'b0, 0, 0);
    run_instr(LD,  1'b0, 0, 3);
    run_instr(BR,  1'b1, 0, 0);
    run_instr(BR,  1'b0, 1, 0);
    run_instr(JALR,1'b0, 0, 0);
    run_instr(ST,  1'b0, 2, 1);
    run_instr(LUI, 1'b0, 0, 0);
    run_instr(JAL, 1'b1, 4, 0);
    run_instr(LD,  1'b0, 0, 4);

    // Random stream; waits of 4 land on the timeout cycle where ready wins.
    for (int n = 0; n < 40; n++)
      run_instr(op_tab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));

    // Unsupported opcode halts with illegal set and no further requests.
    op = SYS;
    fetch(0);
    cyc(1'b1, '0, "decode_illegal");
    halt_cycles(1'b1, 1'b0);
    do_reset();
    run_instr(REG, 1'b0, 0, 0);

    // Fetch timeout: four low-ready waits, request drops on the fifth cycle.
    op = IMM;
    for (int i = 0; i < 4; i++) cyc(1'b0, pk(1,0,0,0,0,2'd0,0,2'd0,0,0,0), "fetch_wait");
    cyc(1'b0, '0, "fetch_timeout");
    halt_cycles(1'b0, 1'b1);
    do_reset();

    // Memory-phase timeout on a load.
    op = LD;
    fetch(0);
    cyc(1'b0, '0, "decode");
    cyc(1'b0, pk(0,0,0,0,1,2'd0,0,2'd0,0,0,0), "exec");
    for (int i = 0; i < 4; i++) cyc(1'b0, pk(1,0,1,0,0,2'd0,0,2'd0,0,0,0), "mem_wait");
    cyc(1'b0, '0, "mem_timeout");
    halt_cycles(1'b0, 1'b1);
    do_reset();

    // Reset asserted in the middle of a memory access.
    run_instr(IMM, 1'b0, 0, 0);
    op = ST;
    fetch(0);
    cyc(1'b0, '0, "decode");
    cyc(1'b0, pk(0,0,0,0,1,2'd0,0,2'd0,0,0,0), "exec");
    cyc(1'b0, pk(1,1,1,0,0,2'd0,0,2'd0,0,0,0), "mem_wait");
    @(negedge clk);
    do_reset();
    run_instr(ST, 1'b0, 0, 0);
    run_instr(IMM, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
